// File: rtl/wb_commit_monitor.sv
// wb_commit_monitor
// Captures each retiring writeback instruction into a commit record, buffers
// the records in a small FIFO drained by the difftest/trace bridge, and keeps
// retire/cycle counters, ebreak halt detection, a no-commit watchdog and a
// sticky overflow flag.
//
// Halt FSM
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_RUN    | normal operation, retires are captured
//   S_DRAIN  | ebreak captured, further retires ignored, waiting for FIFO empty
//   S_HALTED | ebreak record consumed by the bridge, left only by reset
module wb_commit_monitor #(
    parameter int PC_WD      = 64,
    parameter int INST_WD    = 32,
    parameter int RF_ADDR_WD = 5,
    parameter int RF_DATA_WD = 64,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ws_valid,
    input  logic [PC_WD-1:0]      ws_pc,
    input  logic [INST_WD-1:0]    ws_inst,
    input  logic                  ws_exp,
    input  logic                  ws_mret,
    input  logic                  ws_rf_wen,
    input  logic [RF_ADDR_WD-1:0] ws_rf_wnum,
    input  logic [RF_DATA_WD-1:0] ws_rf_wdata,
    input  logic                  cmt_ready,
    output logic                  cmt_valid,
    output logic [PC_WD-1:0]      cmt_pc,
    output logic [INST_WD-1:0]    cmt_inst,
    output logic                  cmt_exp,
    output logic                  cmt_mret,
    output logic                  cmt_rf_wen,
    output logic [RF_ADDR_WD-1:0] cmt_rf_wnum,
    output logic [RF_DATA_WD-1:0] cmt_rf_wdata,
    output logic [63:0]           inst_cnt,
    output logic [63:0]           cycle_cnt,
    output logic                  halt,
    output logic [RF_DATA_WD-1:0] halt_code,
    output logic                  timeout,
    output logic                  overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int REC_W = PC_WD + INST_WD + 3 + RF_ADDR_WD + RF_DATA_WD;

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    localparam logic [INST_WD-1:0]    EBREAK  = INST_WD'(32'h0010_0073);
    localparam logic [RF_ADDR_WD-1:0] A0_NUM  = RF_ADDR_WD'(10);
    localparam logic [TW-1:0]         TO_MAX  = TW'(TIMEOUT);

    logic [1:0]            r_state;
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [REC_W-1:0]      r_mem [DEPTH];
    logic [RF_DATA_WD-1:0] r_a0;
    logic [RF_DATA_WD-1:0] r_halt_code;
    logic [63:0]           r_inst_cnt;
    logic [63:0]           r_cycle_cnt;
    logic [TW-1:0]         r_idle_cnt;
    logic                  r_timeout;
    logic                  r_overflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_drop;
    logic                  w_last;
    logic                  w_rf_wen;
    logic [REC_W-1:0]      w_wr_rec;
    logic [REC_W-1:0]      w_rd_rec;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Retires are only sampled while running; DRAIN and HALTED ignore them.
    assign w_push   = ws_valid && (r_state == S_RUN);
    assign w_pop    = !w_empty && cmt_ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign w_wr     = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;
    assign w_last   = ((r_wr_ptr - r_rd_ptr) == (AW+1)'(1));
    // x0 is hardwired zero, so a write to it is not a register write.
    assign w_rf_wen = ws_rf_wen && (ws_rf_wnum != '0);

    assign w_wr_rec = {ws_pc, ws_inst, ws_exp, ws_mret, w_rf_wen, ws_rf_wnum, ws_rf_wdata};
    assign w_rd_rec = r_mem[r_rd_ptr[AW-1:0]];

    assign {cmt_pc, cmt_inst, cmt_exp, cmt_mret, cmt_rf_wen, cmt_rf_wnum, cmt_rf_wdata} = w_rd_rec;
    assign cmt_valid = !w_empty;
    assign inst_cnt  = r_inst_cnt;
    assign cycle_cnt = r_cycle_cnt;
    assign halt      = (r_state == S_HALTED);
    assign halt_code = r_halt_code;
    assign timeout   = r_timeout;
    assign overflow  = r_overflow;

    // Commit record storage, written at the write pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wr_rec;
        end
    end

    // FIFO pointers, overflow flag and retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_inst_cnt <= '0;
        end else begin
            if (w_wr)   r_wr_ptr   <= r_wr_ptr + 1'b1;
            if (w_drop) r_overflow <= 1'b1;
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_inst_cnt <= r_inst_cnt + 64'd1;
            end
        end
    end

    // a0 shadow and halt code; halt code takes a0 as it was before this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a0        <= '0;
            r_halt_code <= '0;
        end else begin
            if (w_push && w_rf_wen && (ws_rf_wnum == A0_NUM)) r_a0 <= ws_rf_wdata;
            if (w_push && (ws_inst == EBREAK))                r_halt_code <= r_a0;
        end
    end

    // Halt FSM: ebreak capture starts the drain, emptying the FIFO halts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            case (r_state)
                S_RUN:    if (w_push && (ws_inst == EBREAK)) r_state <= S_DRAIN;
                S_DRAIN:  if (w_pop && w_last)               r_state <= S_HALTED;
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_RUN;
            endcase
        end
    end

    // Cycle counter runs until halt, then freezes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= '0;
        end else if (r_state != S_HALTED) begin
            r_cycle_cnt <= r_cycle_cnt + 64'd1;
        end
    end

    // No-commit watchdog, active only while running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (w_push) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != TO_MAX) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
                if (r_idle_cnt == TO_MAX - 1'b1) r_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_commit_monitor.sv
// Directed bench for wb_commit_monitor: in-order commit, overflow, full-FIFO
// push+pop, ebreak halt with a0 code, x0 write suppression, watchdog and
// asynchronous reset.
module tb_wb_commit_monitor;

    localparam int TIMEOUT = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ws_valid = 1'b0;
    logic [63:0] ws_pc = '0;
    logic [31:0] ws_inst = '0;
    logic        ws_exp = 1'b0;
    logic        ws_mret = 1'b0;
    logic        ws_rf_wen = 1'b0;
    logic [4:0]  ws_rf_wnum = '0;
    logic [63:0] ws_rf_wdata = '0;
    logic        cmt_ready = 1'b0;
    logic        cmt_valid;
    logic [63:0] cmt_pc;
    logic [31:0] cmt_inst;
    logic        cmt_exp;
    logic        cmt_mret;
    logic        cmt_rf_wen;
    logic [4:0]  cmt_rf_wnum;
    logic [63:0] cmt_rf_wdata;
    logic [63:0] inst_cnt;
    logic [63:0] cycle_cnt;
    logic        halt;
    logic [63:0] halt_code;
    logic        timeout;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    wb_commit_monitor #(
        .PC_WD(64), .INST_WD(32), .RF_ADDR_WD(5), .RF_DATA_WD(64),
        .DEPTH(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_inst(ws_inst),
        .ws_exp(ws_exp), .ws_mret(ws_mret), .ws_rf_wen(ws_rf_wen),
        .ws_rf_wnum(ws_rf_wnum), .ws_rf_wdata(ws_rf_wdata),
        .cmt_ready(cmt_ready), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
        .cmt_inst(cmt_inst), .cmt_exp(cmt_exp), .cmt_mret(cmt_mret),
        .cmt_rf_wen(cmt_rf_wen), .cmt_rf_wnum(cmt_rf_wnum),
        .cmt_rf_wdata(cmt_rf_wdata), .inst_cnt(inst_cnt),
        .cycle_cnt(cycle_cnt), .halt(halt), .halt_code(halt_code),
        .timeout(timeout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic retire(input logic [63:0] pc, input logic [31:0] inst,
                          input logic wen, input logic [4:0] wnum, input logic [63:0] wdata);
        ws_valid    = 1'b1;
        ws_pc       = pc;
        ws_inst     = inst;
        ws_rf_wen   = wen;
        ws_rf_wnum  = wnum;
        ws_rf_wdata = wdata;
    endtask

    task automatic idle();
        ws_valid  = 1'b0;
        ws_rf_wen = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        cmt_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        reset = 1'b0;
        check("rst_valid", cmt_valid, 0);
        check("rst_pc", cmt_pc, 0);
        check("rst_inst_cnt", inst_cnt, 0);
        check("rst_cycle_cnt", cycle_cnt, 0);
        check("rst_halt", halt, 0);
        check("rst_halt_code", halt_code, 0);
        check("rst_timeout", timeout, 0);
        check("rst_overflow", overflow, 0);

        // Three retires streamed with cmt_ready high
        cmt_ready = 1'b1;
        retire(64'h8000_0000, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
        tick();
        check("t1_valid0", cmt_valid, 1);
        check("t1_pc0", cmt_pc, 64'h8000_0000);
        retire(64'h8000_0004, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
        tick();
        check("t1_pc1", cmt_pc, 64'h8000_0004);
        check("t1_cnt1", inst_cnt, 1);
        retire(64'h8000_0008, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
        tick();
        check("t1_valid2", cmt_valid, 1);
        check("t1_pc2", cmt_pc, 64'h8000_0008);
        idle();
        tick();
        check("t1_empty", cmt_valid, 0);
        check("t1_inst_cnt", inst_cnt, 3);
        check("t1_cycle_cnt", cycle_cnt, 4);

        // Five retires into a 4-deep FIFO with the bridge stalled
        cmt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            retire(64'h100 + 64'(4 * i), 32'h0000_0013, 1'b0, 5'd0, 64'd0);
            tick();
            if (i == 3) check("t2_no_ovf_at_4", overflow, 0);
        end
        check("t2_overflow", overflow, 1);
        check("t2_head", cmt_pc, 64'h100);
        idle();
        cmt_ready = 1'b1;
        tick();
        check("t2_drain1", cmt_pc, 64'h104);
        tick();
        check("t2_drain2", cmt_pc, 64'h108);
        tick();
        check("t2_drain3", cmt_pc, 64'h10C);
        tick();
        check("t2_drained", cmt_valid, 0);
        check("t2_inst_cnt", inst_cnt, 7);

        // Full FIFO with simultaneous push and pop
        do_reset();
        check("t3_reset_ovf", overflow, 0);
        check("t3_reset_cnt", inst_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            retire(64'h200 + 64'(4 * i), 32'h0000_0013, 1'b0, 5'd0, 64'd0);
            tick();
        end
        cmt_ready = 1'b1;
        retire(64'h210, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
        tick();
        check("t3_pushpop_ovf", overflow, 0);
        check("t3_pushpop_head", cmt_pc, 64'h204);
        cmt_ready = 1'b0;
        retire(64'h214, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
        tick();
        check("t3_still_full", overflow, 1);
        idle();
        cmt_ready = 1'b1;
        tick();
        check("t3_order1", cmt_pc, 64'h208);
        tick();
        check("t3_order2", cmt_pc, 64'h20C);
        tick();
        check("t3_order3", cmt_pc, 64'h210);
        tick();
        check("t3_empty", cmt_valid, 0);

        // a0 write, ebreak, trailing retires ignored, delayed drain
        do_reset();
        retire(64'h300, 32'h02a0_0513, 1'b1, 5'd10, 64'h2A);
        tick();
        retire(64'h304, 32'h0010_0073, 1'b0, 5'd0, 64'd0);
        tick();
        retire(64'h308, 32'h0000_0013, 1'b1, 5'd10, 64'h77);
        tick();
        retire(64'h30C, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
        tick();
        idle();
        tick();
        check("t4_cycle_drain", cycle_cnt, 5);
        check("t4_head_wen", cmt_rf_wen, 1);
        check("t4_head_wnum", cmt_rf_wnum, 10);
        check("t4_no_halt_yet", halt, 0);
        cmt_ready = 1'b1;
        tick();
        check("t4_head_ebreak", cmt_inst, 32'h0010_0073);
        check("t4_halt_pending", halt, 0);
        tick();
        check("t4_halt", halt, 1);
        check("t4_inst_cnt", inst_cnt, 2);
        check("t4_trailing_ignored", cmt_valid, 0);
        check("t4_halt_code", halt_code, 64'h2A);
        check("t4_cycle_at_halt", cycle_cnt, 7);
        tick();
        tick();
        check("t4_cycle_frozen", cycle_cnt, 7);
        check("t4_overflow", overflow, 0);

        // x0 write suppression, watchdog, async reset
        do_reset();
        cmt_ready = 1'b1;
        retire(64'h400, 32'h0550_0013, 1'b1, 5'd0, 64'h55);
        tick();
        check("t5_x0_valid", cmt_valid, 1);
        check("t5_x0_wen", cmt_rf_wen, 0);
        check("t5_x0_wdata", cmt_rf_wdata, 64'h55);
        idle();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("t5_no_timeout_yet", timeout, 0);
        tick();
        check("t5_timeout", timeout, 1);
        check("t5_inst_cnt", inst_cnt, 1);
        cmt_ready = 1'b0;
        retire(64'h500, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_valid", cmt_valid, 0);
        check("t6_rst_pc", cmt_pc, 0);
        check("t6_rst_inst_cnt", inst_cnt, 0);
        check("t6_rst_cycle", cycle_cnt, 0);
        check("t6_rst_timeout", timeout, 0);
        check("t6_rst_halt", halt, 0);
        idle();
        tick();
        reset = 1'b0;
        tick();
        check("t6_post_rst_empty", cmt_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
